// File: rtl/arm7tdmi_cp_ctrl.sv
// Coprocessor handshake controller: one CDP/LDC/STC/MRC/MCR at a time,
// with absent-CP filtering, bounded busy-wait, data/beat transfer and a one-cycle response.
module arm7tdmi_cp_ctrl #(
   parameter logic [15:0] CP_PRESENT = 16'hC000,
   parameter int          MAX_BURST  = 16,
   parameter int          TIMEOUT    = 64,
   localparam int         CNT_W      = $clog2(MAX_BURST + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [2:0]       req_op,
   input  logic [3:0]       req_cpnum,
   input  logic [CNT_W-1:0] req_count,
   input  logic [31:0]      req_wdata,
   output logic             cp_cpi,
   output logic [3:0]       cp_num,
   output logic [2:0]       cp_op,
   input  logic             cp_cpa,
   input  logic             cp_cpb,
   output logic [31:0]      cp_wdata,
   output logic             cp_wvalid,
   input  logic [31:0]      cp_rdata,
   output logic             mem_beat,
   input  logic             mem_ready,
   output logic             rsp_valid,
   output logic             rsp_undef,
   output logic             rsp_timeout,
   output logic [31:0]      rsp_rdata,
   output logic [2:0]       dbg_state
);

   localparam int BUSY_W = $clog2(TIMEOUT + 2);

   localparam logic [2:0] OP_CDP = 3'b000;
   localparam logic [2:0] OP_LDC = 3'b001;
   localparam logic [2:0] OP_STC = 3'b010;
   localparam logic [2:0] OP_MRC = 3'b100;
   localparam logic [2:0] OP_MCR = 3'b110;

   typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_HANDSHAKE, S_XFER, S_RESP} state_t;

   state_t            state_q, state_d;
   logic [2:0]        op_q, op_d;
   logic [3:0]        num_q, num_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_clamp;
   logic [31:0]       wdata_q, wdata_d;
   logic [31:0]       rdata_q, rdata_d;
   logic [BUSY_W-1:0] busy_q, busy_d;
   logic              undef_q, undef_d;
   logic              tmo_q, tmo_d;
   logic              op_bad;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         op_q    <= '0;
         num_q   <= '0;
         cnt_q   <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         busy_q  <= '0;
         undef_q <= 1'b0;
         tmo_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         num_q   <= num_d;
         cnt_q   <= cnt_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         busy_q  <= busy_d;
         undef_q <= undef_d;
         tmo_q   <= tmo_d;
      end
   end

   // A zero word count still moves one word; oversize counts saturate.
   always_comb begin
      if (req_count == '0)
         cnt_clamp = CNT_W'(1);
      else if (req_count > CNT_W'(MAX_BURST))
         cnt_clamp = CNT_W'(MAX_BURST);
      else
         cnt_clamp = req_count;
   end

   assign op_bad = (req_op == 3'b011) || (req_op == 3'b101) || (req_op == 3'b111);

   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      num_d   = num_q;
      cnt_d   = cnt_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      busy_d  = busy_q;
      undef_d = undef_q;
      tmo_d   = tmo_q;
      case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               op_d    = req_op;
               num_d   = req_cpnum;
               cnt_d   = cnt_clamp;
               wdata_d = req_wdata;
               tmo_d   = 1'b0;
               if (!CP_PRESENT[req_cpnum] || op_bad) begin
                  undef_d = 1'b1;
                  state_d = S_RESP;
               end else begin
                  undef_d = 1'b0;
                  state_d = S_ISSUE;
               end
            end
         end
         S_ISSUE: begin
            busy_d  = '0;
            state_d = S_HANDSHAKE;
         end
         S_HANDSHAKE: begin
            // Absent beats busy; a busy coprocessor only costs cycles until the limit.
            if (cp_cpa) begin
               undef_d = 1'b1;
               state_d = S_RESP;
            end else if (cp_cpb) begin
               busy_d = busy_q + BUSY_W'(1);
               if ((TIMEOUT != 0) && (busy_d == BUSY_W'(TIMEOUT))) begin
                  undef_d = 1'b1;
                  tmo_d   = 1'b1;
                  state_d = S_RESP;
               end
            end else if (op_q == OP_CDP) begin
               state_d = S_RESP;
            end else begin
               state_d = S_XFER;
            end
         end
         S_XFER: begin
            if (op_q == OP_MCR) begin
               state_d = S_RESP;
            end else if (op_q == OP_MRC) begin
               rdata_d = cp_rdata;
               state_d = S_RESP;
            end else if (mem_ready) begin
               cnt_d = cnt_q - CNT_W'(1);
               if (cnt_q == CNT_W'(1)) state_d = S_RESP;
            end
         end
         S_RESP:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   assign req_ready   = (state_q == S_IDLE);
   assign cp_cpi      = (state_q == S_ISSUE);
   assign cp_num      = (state_q == S_IDLE) ? 4'd0 : num_q;
   assign cp_op       = (state_q == S_IDLE) ? 3'd0 : op_q;
   assign cp_wvalid   = (state_q == S_XFER) && (op_q == OP_MCR);
   assign cp_wdata    = cp_wvalid ? wdata_q : 32'd0;
   assign mem_beat    = (state_q == S_XFER) && ((op_q == OP_LDC) || (op_q == OP_STC));
   assign rsp_valid   = (state_q == S_RESP);
   assign rsp_undef   = rsp_valid && undef_q;
   assign rsp_timeout = rsp_valid && tmo_q;
   assign rsp_rdata   = rdata_q;
   assign dbg_state   = state_q;

endmodule

// File: tb/tb_arm7tdmi_cp_ctrl.sv
// Bench for arm7tdmi_cp_ctrl: per-transaction timeline model built from the
// cycle rules, checked against the DUT every cycle, plus directed scenarios.
module tb_arm7tdmi_cp_ctrl;

   localparam logic [15:0] CPP  = 16'hC000;
   localparam int          TMO  = 64;
   localparam int          CW   = 5;
   localparam int          MAXC = 256;

   logic          clk, rst_n;
   logic          req_valid, req_ready;
   logic [2:0]    req_op;
   logic [3:0]    req_cpnum;
   logic [CW-1:0] req_count;
   logic [31:0]   req_wdata;
   logic          cp_cpi, cp_cpa, cp_cpb, cp_wvalid;
   logic [3:0]    cp_num;
   logic [2:0]    cp_op;
   logic [31:0]   cp_wdata, cp_rdata, rsp_rdata;
   logic          mem_beat, mem_ready;
   logic          rsp_valid, rsp_undef, rsp_timeout;
   logic [2:0]    dbg_state;

   arm7tdmi_cp_ctrl #(.CP_PRESENT(CPP), .MAX_BURST(16), .TIMEOUT(TMO)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
      .req_cpnum(req_cpnum), .req_count(req_count), .req_wdata(req_wdata),
      .cp_cpi(cp_cpi), .cp_num(cp_num), .cp_op(cp_op), .cp_cpa(cp_cpa), .cp_cpb(cp_cpb),
      .cp_wdata(cp_wdata), .cp_wvalid(cp_wvalid), .cp_rdata(cp_rdata),
      .mem_beat(mem_beat), .mem_ready(mem_ready),
      .rsp_valid(rsp_valid), .rsp_undef(rsp_undef), .rsp_timeout(rsp_timeout),
      .rsp_rdata(rsp_rdata), .dbg_state(dbg_state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // stimulus timeline and expected outputs, indexed by cycle offset from acceptance
   bit          s_cpa[MAXC], s_cpb[MAXC], s_rdy[MAXC];
   logic [31:0] s_rd[MAXC];
   bit          e_rdy[MAXC], e_cpi[MAXC], e_wv[MAXC], e_beat[MAXC];
   bit          e_rsp[MAXC], e_und[MAXC], e_tmo[MAXC];
   logic [3:0]  e_num[MAXC];
   logic [2:0]  e_op[MAXC];
   logic [31:0] e_wdata[MAXC], e_rdata[MAXC];
   int          resp_k, mrc_k, cur_k;
   logic [31:0] model_rdata;
   bit          chk_en, in_idle;
   int          n_tests, n_fail;
   int          cnt_cpi, cnt_wv, cnt_acc, cnt_rsp;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s t=%0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         if (in_idle) begin
            check("idle_ready", req_ready, 1);
            check("idle_cpi", cp_cpi, 0);
            check("idle_num", cp_num, 0);
            check("idle_op", cp_op, 0);
            check("idle_wvalid", cp_wvalid, 0);
            check("idle_beat", mem_beat, 0);
            check("idle_rsp", rsp_valid, 0);
            check("idle_rdata", rsp_rdata, model_rdata);
         end else begin
            check("req_ready", req_ready, e_rdy[cur_k]);
            check("cp_cpi", cp_cpi, e_cpi[cur_k]);
            check("cp_num", cp_num, e_num[cur_k]);
            check("cp_op", cp_op, e_op[cur_k]);
            check("cp_wvalid", cp_wvalid, e_wv[cur_k]);
            check("cp_wdata", cp_wdata, e_wdata[cur_k]);
            check("mem_beat", mem_beat, e_beat[cur_k]);
            check("rsp_valid", rsp_valid, e_rsp[cur_k]);
            check("rsp_undef", rsp_undef, e_und[cur_k]);
            check("rsp_timeout", rsp_timeout, e_tmo[cur_k]);
            check("rsp_rdata", rsp_rdata, e_rdata[cur_k]);
         end
         if (cp_cpi) cnt_cpi++;
         if (cp_wvalid) cnt_wv++;
         if (mem_beat && mem_ready) cnt_acc++;
         if (rsp_valid) cnt_rsp++;
      end
   end

   // Expected timeline from the cycle rules: issue at 1, handshake from 2,
   // each busy cycle delays by one, transfer follows the grant, response last.
   task automatic build_exp(input logic [2:0] op, input logic [3:0] num,
                            input logic [CW-1:0] cnt, input logic [31:0] wdata);
      int t, busy, n, x;
      bit ok, done;
      logic [15:0] pres;
      pres = CPP;
      for (int k = 0; k < MAXC; k++) begin
         e_rdy[k] = 0; e_cpi[k] = 0; e_wv[k] = 0; e_beat[k] = 0;
         e_rsp[k] = 0; e_und[k] = 0; e_tmo[k] = 0;
         e_num[k] = num; e_op[k] = op; e_wdata[k] = 0; e_rdata[k] = model_rdata;
      end
      e_rdy[0] = 1; e_num[0] = 0; e_op[0] = 0;
      mrc_k = -1;
      ok = pres[num] && (op == 3'd0 || op == 3'd1 || op == 3'd2 || op == 3'd4 || op == 3'd6);
      resp_k = MAXC - 1;
      if (!ok) begin
         resp_k = 1; e_und[1] = 1;
      end else begin
         e_cpi[1] = 1; t = 2; busy = 0; done = 0;
         while (!done && t < MAXC - 3) begin
            if (s_cpa[t]) begin
               resp_k = t + 1; e_und[t + 1] = 1; done = 1;
            end else if (s_cpb[t]) begin
               busy++;
               if (TMO != 0 && busy == TMO) begin
                  resp_k = t + 1; e_und[t + 1] = 1; e_tmo[t + 1] = 1; done = 1;
               end else t++;
            end else begin
               x = t + 1;
               if (op == 3'd0) resp_k = t + 1;
               else if (op == 3'd6) begin
                  e_wv[x] = 1; e_wdata[x] = wdata; resp_k = x + 1;
               end else if (op == 3'd4) begin
                  mrc_k = x; e_rdata[x + 1] = s_rd[x]; resp_k = x + 1;
               end else begin
                  n = (cnt == 0) ? 1 : ((cnt > 16) ? 16 : int'(cnt));
                  while (n > 0 && x < MAXC - 2) begin
                     e_beat[x] = 1;
                     if (s_rdy[x]) n--;
                     x++;
                  end
                  resp_k = x;
               end
               done = 1;
            end
         end
      end
      e_rsp[resp_k] = 1;
   endtask

   task automatic clear_stim();
      for (int k = 0; k < MAXC; k++) begin
         s_cpa[k] = 0; s_cpb[k] = 0; s_rdy[k] = 1; s_rd[k] = $urandom;
      end
   endtask

   task automatic rand_stim();
      for (int k = 0; k < MAXC; k++) begin
         s_cpa[k] = ($urandom_range(0, 24) == 0);
         s_cpb[k] = (k < 12) ? ($urandom_range(0, 2) == 0) : 1'b0;
         s_rdy[k] = (k > 100) ? 1'b1 : 1'($urandom_range(0, 1));
         s_rd[k]  = $urandom;
      end
   endtask

   task automatic idle_cycles(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
         req_valid = 0; req_op = 3'($urandom); req_cpnum = 4'($urandom);
         cp_cpa = 1'($urandom); cp_cpb = 1'($urandom); mem_ready = 1'($urandom);
         cp_rdata = $urandom;
         in_idle = 1; chk_en = 1;
      end
   endtask

   task automatic run_txn(input logic [2:0] op, input logic [3:0] num,
                          input logic [CW-1:0] cnt, input logic [31:0] wdata, input int abort_k);
      cnt_cpi = 0; cnt_wv = 0; cnt_acc = 0; cnt_rsp = 0;
      build_exp(op, num, cnt, wdata);
      if (resp_k >= MAXC - 3) check("model_bound", resp_k, 0);
      for (int k = 0; k <= resp_k; k++) begin
         @(posedge clk); #1;
         req_valid = (k == 0);
         if (k == 0) begin
            req_op = op; req_cpnum = num; req_count = cnt; req_wdata = wdata;
         end else begin
            req_op = 3'($urandom); req_cpnum = 4'($urandom);
            req_count = CW'($urandom); req_wdata = $urandom;
         end
         cp_cpa = s_cpa[k]; cp_cpb = s_cpb[k]; mem_ready = s_rdy[k]; cp_rdata = s_rd[k];
         cur_k = k; in_idle = 0; chk_en = 1;
         if (k == abort_k) begin
            chk_en = 0;
            check("abort_beat_before", mem_beat, 1);
            #1 rst_n = 0;
            #1;
            check("abort_beat_drop", mem_beat, 0);
            check("abort_no_rsp", rsp_valid, 0);
            check("abort_ready", req_ready, 1);
            check("abort_num", cp_num, 0);
            @(negedge clk); @(negedge clk);
            rst_n = 1;
            model_rdata = 0;
            return;
         end
      end
      if (mrc_k >= 0) model_rdata = s_rd[mrc_k];
      @(negedge clk); #1;
   endtask

   initial begin
      n_tests = 0; n_fail = 0; chk_en = 0; in_idle = 1; cur_k = 0; model_rdata = 0;
      rst_n = 0; req_valid = 1; req_op = 3'b110; req_cpnum = 4'd15; req_count = 5'd3;
      req_wdata = 32'hFFFF_FFFF; cp_cpa = 0; cp_cpb = 1; cp_rdata = 32'hA5A5A5A5; mem_ready = 1;
      #12;
      check("rst_ready", req_ready, 1);
      check("rst_cpi", cp_cpi, 0);
      check("rst_num", cp_num, 0);
      check("rst_op", cp_op, 0);
      check("rst_wvalid", cp_wvalid, 0);
      check("rst_wdata", cp_wdata, 0);
      check("rst_beat", mem_beat, 0);
      check("rst_rsp", {rsp_valid, rsp_undef, rsp_timeout}, 0);
      check("rst_rdata", rsp_rdata, 0);
      @(negedge clk);
      rst_n = 1; req_valid = 0;

      // MCR to CP15
      clear_stim();
      run_txn(3'b110, 4'd15, 5'd0, 32'hDEADBEEF, -1);
      check("mcr_resp_cycle", resp_k, 4);
      check("mcr_wvalid_cnt", cnt_wv, 1);
      check("mcr_rsp_cnt", cnt_rsp, 1);

      // CDP to an unfitted CP3
      clear_stim();
      run_txn(3'b000, 4'd3, 5'd0, 32'h0, -1);
      check("rej_resp_cycle", resp_k, 1);
      check("rej_cpi_cnt", cnt_cpi, 0);

      // MRC to CP14 with five busy cycles
      clear_stim();
      for (int k = 2; k < 7; k++) s_cpb[k] = 1;
      s_rd[8] = 32'h12345678;
      run_txn(3'b100, 4'd14, 5'd0, 32'h0, -1);
      check("mrc_resp_cycle", resp_k, 9);
      idle_cycles(1);
      @(negedge clk); #1;
      check("mrc_rdata_hold", rsp_rdata, 32'h12345678);

      // LDC count 4, mem_ready alternating
      clear_stim();
      for (int k = 0; k < MAXC; k++) s_rdy[k] = k[0];
      run_txn(3'b001, 4'd15, 5'd4, 32'h0, -1);
      check("ldc4_beats", cnt_acc, 4);
      check("ldc4_rsp_cnt", cnt_rsp, 1);

      clear_stim();
      run_txn(3'b010, 4'd15, 5'd0, 32'h0, -1);
      check("cnt0_beats", cnt_acc, 1);
      clear_stim();
      run_txn(3'b001, 4'd14, 5'd31, 32'h0, -1);
      check("cnt31_beats", cnt_acc, 16);
      check("cnt31_resp_cycle", resp_k, 19);

      // busy held high until the timeout
      clear_stim();
      for (int k = 0; k < MAXC; k++) s_cpb[k] = 1;
      run_txn(3'b110, 4'd15, 5'd0, 32'h55AA55AA, -1);
      check("tmo_resp_cycle", resp_k, 66);
      check("tmo_wvalid_cnt", cnt_wv, 0);

      // absent and busy together
      clear_stim();
      s_cpa[2] = 1; s_cpb[2] = 1;
      run_txn(3'b110, 4'd14, 5'd0, 32'h1, -1);
      check("cpa_wins_cycle", resp_k, 3);

      // reset during the second LDC beat, then a normal request
      clear_stim();
      run_txn(3'b001, 4'd15, 5'd4, 32'h0, 4);
      idle_cycles(3);
      clear_stim();
      run_txn(3'b110, 4'd15, 5'd0, 32'hCAFEF00D, -1);
      check("post_rst_resp_cycle", resp_k, 4);

      for (int i = 0; i < 60; i++) begin
         logic [3:0] num;
         rand_stim();
         num = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'(14 + $urandom_range(0, 1));
         run_txn(3'($urandom_range(0, 7)), num, CW'($urandom_range(0, 31)), $urandom, -1);
         idle_cycles($urandom_range(0, 2));
      end

      chk_en = 0;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
